// File: rtl/controle_complemento2_serial_if.sv
// Handshake and data bundle for the bit-serial two's-complement sequencer.
interface controle_complemento2_serial_if #(
  parameter int N = 8
);
  logic         start;
  logic         select;
  logic [N-1:0] A;
  logic [N-1:0] R;
  logic         Cout;
  logic         overflow;
  logic         busy;
  logic         done;

  modport master (
    output start, select, A,
    input  R, Cout, overflow, busy, done
  );

  modport slave (
    input  start, select, A,
    output R, Cout, overflow, busy, done
  );
endinterface

// File: rtl/controle_complemento2_serial.sv
// Bit-serial sequencer: streams an N-bit operand LSB-first through one
// two's-complement slice, carry held in a flop, result assembled in a
// shift register and reported with a one-cycle done pulse.
module controle_complemento2_serial #(
  parameter int N = 8
) (
  input logic                          clk,
  input logic                          reset,
  controle_complemento2_serial_if.slave bus
);

  localparam int            CW   = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // Single complement slice: returns {result_bit, carry_out}.
  function automatic logic [1:0] slice_cell(input logic a, input logic c, input logic sel);
    logic r;
    r = sel ? (~a ^ c) : a;
    return {r, ~a & c};
  endfunction

  state_t        state_q, state_d;
  logic [N-1:0]  a_sr_q, a_sr_d;
  logic [N-1:0]  r_sr_q, r_sr_d;
  logic          c_q, c_d;
  logic          sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  r_q, r_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;

  logic          slice_r, slice_c;
  logic [N-1:0]  r_sr_next;

  assign {slice_r, slice_c} = slice_cell(a_sr_q[0], c_q, sel_q);
  assign r_sr_next          = {slice_r, r_sr_q[N-1:1]};

  // Next-state and datapath update for the IDLE/SHIFT/DONE sequencer.
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    r_sr_d  = r_sr_q;
    c_d     = c_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_sr_d  = bus.A;
          sel_d   = bus.select;
          c_d     = 1'b1;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        r_sr_d = r_sr_next;
        a_sr_d = {1'b0, a_sr_q[N-1:1]};
        c_d    = slice_c;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // Last bit: a_sr_q[0] is the captured operand MSB here, and the
          // outputs are loaded so they are valid during the DONE cycle.
          cnt_d   = '0;
          state_d = DONE;
          r_d     = r_sr_next;
          cout_d  = slice_c;
          ovf_d   = sel_q & a_sr_q[0] & slice_r;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset clears everything, overriding start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      r_sr_q  <= '0;
      c_q     <= 1'b0;
      sel_q   <= 1'b0;
      cnt_q   <= '0;
      r_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      r_sr_q  <= r_sr_d;
      c_q     <= c_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.R        = r_q;
  assign bus.Cout     = cout_q;
  assign bus.overflow = ovf_q;
  assign bus.busy     = (state_q == SHIFT);
  assign bus.done     = (state_q == DONE);

endmodule

// File: tb/tb_controle_complemento2_serial.sv
// Directed bench for the bit-serial two's-complement sequencer with a
// scoreboard of expected results.
module tb_controle_complemento2_serial;

  localparam int N = 8;

  logic clk;
  logic reset;

  controle_complemento2_serial_if #(.N(N)) bus ();

  controle_complemento2_serial #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] r;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t         sb[$];
  exp_t         last;
  int           errors = 0;
  int           checks = 0;

  function automatic exp_t model(input logic [N-1:0] a, input logic sel);
    exp_t         e;
    logic [N-1:0] neg;
    logic [N-1:0] most_neg;
    neg      = ~a + 1'b1;
    most_neg = {1'b1, {(N-1){1'b0}}};
    e.r      = sel ? neg : a;
    e.cout   = (a == '0);
    e.ovf    = sel && (a == most_neg);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for done, counting cycles and busy cycles on the way.
  task automatic wait_done(input bit poke, output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (bus.done !== 1'b1 && lat < 30) begin
      if (bus.busy === 1'b1) bcnt++;
      if (poke && lat == 2) bus.start = 1'b1;
      if (poke && lat == 4) bus.start = 1'b0;
      tick();
      lat++;
    end
  endtask

  task automatic compare_result(input string tag);
    check({tag, "_pending"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      last = sb.pop_front();
      check({tag, "_R"},    32'(bus.R),        32'(last.r));
      check({tag, "_Cout"}, 32'(bus.Cout),     32'(last.cout));
      check({tag, "_ovf"},  32'(bus.overflow), 32'(last.ovf));
    end
  endtask

  task automatic run_op(input string tag, input logic [N-1:0] a, input logic sel, input bit poke);
    int lat;
    int bcnt;
    bus.A      = a;
    bus.select = sel;
    bus.start  = 1'b1;
    sb.push_back(model(a, sel));
    tick();
    bus.start  = 1'b0;
    bus.A      = N'($urandom);
    bus.select = ~sel;
    wait_done(poke, lat, bcnt);
    check({tag, "_latency"}, 32'(lat), 32'(N));
    check({tag, "_busycnt"}, 32'(bcnt), 32'(N));
    check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    compare_result(tag);
    tick();
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_R_hold"}, 32'(bus.R), 32'(last.r));
  endtask

  initial begin
    int lat;
    int bcnt;
    int dcnt;

    bus.start  = 1'b0;
    bus.select = 1'b0;
    bus.A      = '0;
    reset      = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    check("rst_R",    32'(bus.R),        32'd0);
    check("rst_Cout", 32'(bus.Cout),     32'd0);
    check("rst_ovf",  32'(bus.overflow), 32'd0);
    check("rst_busy", 32'(bus.busy),     32'd0);
    check("rst_done", 32'(bus.done),     32'd0);

    // Basic operations
    run_op("neg05",   8'h05, 1'b1, 1'b0);
    run_op("neg00",   8'h00, 1'b1, 1'b0);
    run_op("neg80",   8'h80, 1'b1, 1'b0);
    run_op("pass80",  8'h80, 1'b0, 1'b0);
    run_op("pass5A",  8'h5A, 1'b0, 1'b1);
    run_op("negB7",   8'hB7, 1'b1, 1'b0);

    // Reset aborting an operation on its 3rd SHIFT cycle
    bus.A      = 8'h33;
    bus.select = 1'b1;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    tick();
    tick();
    check("abort_busy_before", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_R",    32'(bus.R),    32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done === 1'b1) dcnt++;
      tick();
    end
    check("abort_no_done", 32'(dcnt), 32'd0);
    run_op("after_abort", 8'h01, 1'b1, 1'b0);

    // start held high: back-to-back operations from the DONE cycle
    bus.A      = 8'h01;
    bus.select = 1'b1;
    bus.start  = 1'b1;
    sb.push_back(model(8'h01, 1'b1));
    sb.push_back(model(8'h01, 1'b1));
    tick();
    wait_done(1'b0, lat, bcnt);
    check("cont1_latency", 32'(lat), 32'(N));
    compare_result("cont1");
    tick();
    check("cont2_started", 32'(bus.busy), 32'd1);
    wait_done(1'b0, lat, bcnt);
    check("cont_period", 32'(lat + 1), 32'(N + 1));
    compare_result("cont2");
    reset = 1'b1;
    tick();
    check("rst_start_busy", 32'(bus.busy), 32'd0);
    check("rst_start_done", 32'(bus.done), 32'd0);
    check("rst_start_R",    32'(bus.R),    32'd0);
    reset     = 1'b0;
    bus.start = 1'b0;
    tick();
    check("rst_start_idle", 32'(bus.busy), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
